param_seq_detector: RTL
=======================

// Module: param_seq_detector
// PURPOSE
//   Parametrised, run-time programmable serial bit-pattern detector, successor to the fixed 4-bit Moore detector.
//   Pattern (1..MAX_LEN bits), length and overlap mode are loaded via a config strobe.
//   Flags each occurrence with a one-cycle registered pulse and keeps a saturating match count.
//   Resets to pattern 1001, length 4, overlap on, so it drops in where the fixed detector sat.
// PARAMETERS
//   MAX_LEN      8        maximum pattern length in bits (>=2)
//   CNT_W        8        width of match_count
//   DEF_PATTERN  8'b1001  pattern loaded at reset (right-aligned, MAX_LEN bits)
//   DEF_LEN      4        pattern length loaded at reset (1..MAX_LEN)
//   DEF_OVERLAP  1        overlap mode loaded at reset
//   LW = $clog2(MAX_LEN+1) (localparam, width of length fields)
// PORTS
//   clock         in   1        rising-edge clock
//   reset         in   1        synchronous, active-high
//   din_valid     in   1        din is sampled only when high
//   din           in   1        serial input bit
//   cfg_load      in   1        load cfg_* fields this cycle
//   cfg_pattern   in   MAX_LEN  new pattern; bit [len-1] is first-received, bit [0] last
//   cfg_len       in   LW       new pattern length
//   cfg_overlap   in   1        1: overlapping matches allowed; 0: history cleared after each match
//   clr_count     in   1        synchronous clear of match_count
//   match         out  1        one-cycle pulse, cycle after completing bit sampled
//   match_count   out  CNT_W    saturating count of matches
//   cfg_err       out  1        one-cycle pulse: cfg_load rejected
//   fill          out  LW       number of valid history bits (0..MAX_LEN)
// BEHAVIOUR
//   - Reset: pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, history=0, fill=0.
//     match=0, match_count=0, cfg_err=0. Reset overrides all other inputs.
//   - Sample cycle (din_valid=1, cfg_load=0):
//     - hist' = {hist[MAX_LEN-2:0], din}; fill' = min(fill+1, MAX_LEN).
//     - hit = (fill' >= len) && (hist'[len-1:0] == pattern[len-1:0]); bits above len are ignored.
//     - match <= hit: registered, latency 1 cycle after the sampling edge.
//   - On hit:
//     - overlap=1: fill keeps fill'.
//     - overlap=0: fill <= 0, so the next match needs len fresh bits.
//   - din_valid=0: history, fill and count hold; match <= 0. Gaps of any length are transparent.
//   - match_count: +1 on each hit; saturates at 2^CNT_W-1, no wrap.
//     - clr_count: count <= 0; clear wins over a simultaneous hit, but match still pulses.
//   - cfg_load=1:
//     - Legal when 1 <= cfg_len <= MAX_LEN. Latch pattern, len and overlap; fill <= 0; match <= 0.
//       din on the same cycle is discarded. match_count is unaffected.
//     - Illegal cfg_len (0 or >MAX_LEN): cfg_err <= 1 for one cycle. Config, history and fill unchanged.
//       din on that cycle is still discarded.
//   - len=1: every valid bit equal to pattern[0] is a match (in either overlap mode).
//   - All outputs are registered; there are no combinational input-to-output paths.
// TESTING
//   1. Reset defaults; stream 1,0,0,1,0,0,1 -> match after bits 4 and 7; count=2.
//   2. Load 1001/len4/overlap=0; same stream -> match after bit 4 only; fill=3 at end; count=1.
//   3. Load 10110/len5; stream 1,0,<valid low 3 cyc>,1,1,0 -> one match after 5th valid bit.
//   4. cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err pulses twice; the 1001 match still works.
//   5. Stream 1,0,0; reset; then 1 -> no match; fill=1; config back to defaults.
//   6. CNT_W=2, len1 pattern 1: five 1s -> count 3 (saturates); clr_count with a hit -> count 0, match=1.

Source files
------------

// File: rtl/param_seq_detector.sv
// param_seq_detector - run-time programmable serial bit-pattern detector
// with a one-cycle match pulse and a saturating match counter.
module param_seq_detector #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b1001,
    parameter int                 DEF_LEN     = 4,
    parameter logic               DEF_OVERLAP = 1'b1,
    localparam int                LW          = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic [LW-1:0]      fill
);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LW-1:0]      len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] hist_s;
    logic [LW-1:0]      fill_s;
    logic               eq;
    logic               hit;
    logic               cfg_ok;

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        cfg_err_d = 1'b0;

        // Candidate history after shifting in the current bit.
        hist_s = {hist_q[MAX_LEN-2:0], din};
        fill_s = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);

        eq = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q) && hist_s[i] != pattern_q[i]) begin
                eq = 1'b0;
            end
        end
        hit    = din_valid && !cfg_load && (fill_s >= len_q) && eq;
        cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));

        if (cfg_load) begin
            if (cfg_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                fill_d    = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (din_valid) begin
            hist_d = hist_s;
            fill_d = (hit && !overlap_q) ? '0 : fill_s;
        end

        match_d = hit;

        // A clear beats a simultaneous hit; the match pulse is unaffected.
        if (clr_count) begin
            count_d = '0;
        end else if (hit && count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LW'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            count_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            count_q   <= count_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign cfg_err     = cfg_err_q;
    assign fill        = fill_q;

endmodule
